// File: rtl/bp_be_pkg.sv
// Back-end calculator types: FMA result tracker entry and completion stage helpers.
package bp_be_pkg;

  localparam int bp_be_reg_addr_width_gp = 5;

  // Default completion stages for imul (latency 3) and fma (latency 4).
  localparam int bp_be_imul_stage_gp = 2;
  localparam int bp_be_fp_stage_gp   = 3;

  typedef struct packed {
    logic                               v;
    logic                               poison;
    logic                               fp;
    logic [bp_be_reg_addr_width_gp-1:0] rd;
  } bp_be_fma_track_entry_s;

  localparam int bp_be_fma_track_entry_width_gp = $bits(bp_be_fma_track_entry_s);

  // Latency counts the issue cycle, so a result returns while its entry sits in S(latency-1).
  function automatic int bp_be_stage_of_latency(input int latency);
    return latency - 1;
  endfunction

endpackage

// File: rtl/bp_common_pkg.sv
// Types shared across the BlackParrot core: RISC-V FP exception flag layout.
package bp_common_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } rv64_fflags_s;

endpackage

// File: rtl/bp_be_fma_track_stage.sv
// One shadow-pipeline entry register; the loaded entry is poisoned when poison_i is high.
module bp_be_fma_track_stage
  import bp_be_pkg::*;
(
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      poison_i,
  input  logic [bp_be_fma_track_entry_width_gp-1:0] entry_i,
  output logic [bp_be_fma_track_entry_width_gp-1:0] entry_o
);

  bp_be_fma_track_entry_s entry_in_s, entry_d, entry_q;

  assign entry_in_s = entry_i;

  always_comb begin
    entry_d        = entry_in_s;
    entry_d.poison = entry_in_s.poison | poison_i;
  end

  // NOTE: state uses non-blocking assignments so every stage samples its neighbour's old value.
  always_ff @(posedge clk_i) begin
    if (reset_i) entry_q <= '0;
    else         entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/bp_be_fma_result_tracker.sv
// Shadow pipeline beside the FMA/IMUL pipe: pairs returning results with rd/file,
// kills flushed writebacks, drives busy masks and accumulates sticky FP flags.
module bp_be_fma_result_tracker
  import bp_common_pkg::*;
  import bp_be_pkg::*;
#(
  parameter int dpath_width_p    = 66,
  parameter int reg_addr_width_p = 5,
  parameter int imul_latency_p   = 3,
  parameter int fma_latency_p    = 4,
  parameter int flush_depth_p    = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        issue_v_i,
  input  logic                        issue_fma_i,
  input  logic [reg_addr_width_p-1:0] issue_rd_i,
  input  logic                        flush_i,
  input  logic [dpath_width_p-1:0]    imul_data_i,
  input  logic                        imul_v_i,
  input  logic [dpath_width_p-1:0]    fma_data_i,
  input  logic [4:0]                  fma_fflags_i,
  input  logic                        fma_v_i,
  input  logic                        fflags_clr_i,
  output logic                        iwb_v_o,
  output logic [reg_addr_width_p-1:0] iwb_rd_o,
  output logic [dpath_width_p-1:0]    iwb_data_o,
  output logic                        fwb_v_o,
  output logic [reg_addr_width_p-1:0] fwb_rd_o,
  output logic [dpath_width_p-1:0]    fwb_data_o,
  output logic [4:0]                  fwb_fflags_o,
  output logic [4:0]                  fflags_acc_o,
  output logic [31:0]                 irf_busy_o,
  output logic [31:0]                 frf_busy_o,
  output logic                        err_o
);

  localparam int imul_stage_lp = bp_be_stage_of_latency(imul_latency_p);
  localparam int fp_stage_lp   = bp_be_stage_of_latency(fma_latency_p);
  localparam int num_stages_lp = fp_stage_lp;
  localparam int ignore_w_lp   = $clog2(fma_latency_p);

  bp_be_fma_track_entry_s issue_entry;
  bp_be_fma_track_entry_s stage_q [1:num_stages_lp];

  always_comb begin
    issue_entry        = '0;
    issue_entry.v      = issue_v_i;
    issue_entry.fp     = issue_fma_i;
    issue_entry.rd     = issue_rd_i;
  end

  // Stage 1 poisons the issuing op; stages up to flush_depth_p poison what they pass on.
  for (genvar g = 1; g <= num_stages_lp; g++) begin : gen_stage
    localparam bit kill_lp = ((g - 1) <= flush_depth_p);
    logic [bp_be_fma_track_entry_width_gp-1:0] entry_in, entry_out;

    if (g == 1) begin : gen_head
      assign entry_in = issue_entry;
    end else begin : gen_body
      assign entry_in = stage_q[g-1];
    end

    bp_be_fma_track_stage u_stage (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .poison_i (kill_lp ? flush_i : 1'b0),
      .entry_i  (entry_in),
      .entry_o  (entry_out)
    );

    assign stage_q[g] = entry_out;
  end

  bp_be_fma_track_entry_s imul_ent, fp_ent;
  logic imul_match, fp_match;

  assign imul_ent   = stage_q[imul_stage_lp];
  assign fp_ent     = stage_q[fp_stage_lp];
  assign imul_match = imul_ent.v & ~imul_ent.fp;
  assign fp_match   = fp_ent.v & fp_ent.fp;

  assign iwb_v_o      = imul_v_i & imul_match & ~imul_ent.poison;
  assign iwb_rd_o     = iwb_v_o ? imul_ent.rd : '0;
  assign iwb_data_o   = iwb_v_o ? imul_data_i : '0;
  assign fwb_v_o      = fma_v_i & fp_match & ~fp_ent.poison;
  assign fwb_rd_o     = fwb_v_o ? fp_ent.rd : '0;
  assign fwb_data_o   = fwb_v_o ? fma_data_i : '0;
  assign fwb_fflags_o = fwb_v_o ? fma_fflags_i : '0;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    irf_busy_o = '0;
    frf_busy_o = '0;
    for (int s = 1; s <= num_stages_lp; s++) begin
      if (s <= imul_stage_lp && stage_q[s].v && !stage_q[s].poison && !stage_q[s].fp
          && stage_q[s].rd != '0)
        irf_busy_o[stage_q[s].rd] = 1'b1;
      if (s <= fp_stage_lp && stage_q[s].v && !stage_q[s].poison && stage_q[s].fp)
        frf_busy_o[stage_q[s].rd] = 1'b1;
    end
  end

  rv64_fflags_s             fflags_acc_d, fflags_acc_q;
  logic                     err_d, err_q;
  logic [ignore_w_lp-1:0]   ignore_d, ignore_q;
  logic                     ignoring;

  assign ignoring = (ignore_q != '0);

  always_comb begin
    ignore_d = ignoring ? ignore_q - ignore_w_lp'(1) : '0;

    fflags_acc_d = fflags_acc_q | (fwb_v_o ? rv64_fflags_s'(fma_fflags_i) : '0);
    if (fflags_clr_i) fflags_acc_d = '0;

    // Late pipe valids from ops dropped by reset are forgiven; missing valids never are.
    err_d = err_q
          | (imul_v_i & ~imul_match & ~ignoring) | (imul_match & ~imul_v_i)
          | (fma_v_i  & ~fp_match   & ~ignoring) | (fp_match   & ~fma_v_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fflags_acc_q <= '0;
      err_q        <= 1'b0;
      ignore_q     <= ignore_w_lp'(num_stages_lp);
    end else begin
      fflags_acc_q <= fflags_acc_d;
      err_q        <= err_d;
      ignore_q     <= ignore_d;
    end
  end

  assign fflags_acc_o = fflags_acc_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_bp_be_fma_result_tracker.sv
// Scoreboard bench: expected writebacks are queued at issue and popped by a negedge monitor.
module tb_bp_be_fma_result_tracker;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        issue_v_i, issue_fma_i, flush_i;
  logic [4:0]  issue_rd_i;
  logic [65:0] imul_data_i, fma_data_i;
  logic        imul_v_i, fma_v_i, fflags_clr_i;
  logic [4:0]  fma_fflags_i;
  logic        iwb_v_o, fwb_v_o, err_o;
  logic [4:0]  iwb_rd_o, fwb_rd_o, fwb_fflags_o, fflags_acc_o;
  logic [65:0] iwb_data_o, fwb_data_o;
  logic [31:0] irf_busy_o, frf_busy_o;

  always #5 clk = ~clk;

  bp_be_fma_result_tracker dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .issue_v_i    (issue_v_i),
    .issue_fma_i  (issue_fma_i),
    .issue_rd_i   (issue_rd_i),
    .flush_i      (flush_i),
    .imul_data_i  (imul_data_i),
    .imul_v_i     (imul_v_i),
    .fma_data_i   (fma_data_i),
    .fma_fflags_i (fma_fflags_i),
    .fma_v_i      (fma_v_i),
    .fflags_clr_i (fflags_clr_i),
    .iwb_v_o      (iwb_v_o),
    .iwb_rd_o     (iwb_rd_o),
    .iwb_data_o   (iwb_data_o),
    .fwb_v_o      (fwb_v_o),
    .fwb_rd_o     (fwb_rd_o),
    .fwb_data_o   (fwb_data_o),
    .fwb_fflags_o (fwb_fflags_o),
    .fflags_acc_o (fflags_acc_o),
    .irf_busy_o   (irf_busy_o),
    .frf_busy_o   (frf_busy_o),
    .err_o        (err_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [65:0] data;
    logic [4:0]  flags;
  } wb_t;

  wb_t iq[$];
  wb_t fq[$];
  wb_t ie, fe;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented writeback must match the oldest expectation for its file.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (iwb_v_o) begin
        if (iq.size() == 0) check("iwb_unexpected", iwb_v_o, 1'b0);
        else begin
          ie = iq.pop_front();
          check("iwb_rd", iwb_rd_o, ie.rd);
          check("iwb_data", iwb_data_o, ie.data);
        end
      end
      if (fwb_v_o) begin
        if (fq.size() == 0) check("fwb_unexpected", fwb_v_o, 1'b0);
        else begin
          fe = fq.pop_front();
          check("fwb_rd", fwb_rd_o, fe.rd);
          check("fwb_data", fwb_data_o, fe.data);
          check("fwb_fflags", fwb_fflags_o, fe.flags);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    issue_v_i    = 1'b0;
    issue_fma_i  = 1'b0;
    issue_rd_i   = '0;
    flush_i      = 1'b0;
    imul_v_i     = 1'b0;
    imul_data_i  = '0;
    fma_v_i      = 1'b0;
    fma_data_i   = '0;
    fma_fflags_i = '0;
    fflags_clr_i = 1'b0;
  endtask

  task automatic issue(input logic fp, input logic [4:0] rd);
    issue_v_i   = 1'b1;
    issue_fma_i = fp;
    issue_rd_i  = rd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    cyc();
    cyc();
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_iwb_v", iwb_v_o, 1'b0);
    check("rst_fwb_v", fwb_v_o, 1'b0);
    check("rst_irf_busy", irf_busy_o, 32'h0);
    check("rst_frf_busy", frf_busy_o, 32'h0);
    check("rst_acc", fflags_acc_o, 5'h0);
    check("rst_err", err_o, 1'b0);
    idle(4);

    // imul rd=7, result 0x2A returns at t2
    cyc(); issue(1'b0, 5'd7); iq.push_back('{5'd7, 66'h2A, 5'h0});
    cyc(); @(negedge clk); check("imul_busy7_t1", irf_busy_o[7], 1'b1);
    cyc(); imul_v_i = 1'b1; imul_data_i = 66'h2A;
    @(negedge clk); check("imul_busy7_t2", irf_busy_o[7], 1'b1);
    check("imul_iwb_v_t2", iwb_v_o, 1'b1);
    cyc(); @(negedge clk); check("imul_busy7_t3", irf_busy_o[7], 1'b0);
    idle(2);

    // imul to x0 still writes back but never marks busy
    cyc(); issue(1'b0, 5'd0); iq.push_back('{5'd0, 66'h55, 5'h0});
    cyc(); @(negedge clk); check("x0_irf_busy", irf_busy_o, 32'h0);
    cyc(); imul_v_i = 1'b1; imul_data_i = 66'h55;
    idle(2);

    // fmadd rd=3 with flag nx
    cyc(); issue(1'b1, 5'd3); fq.push_back('{5'd3, 66'h1_2345_6789_ABCD_EF01, 5'b00001});
    cyc();
    cyc(); @(negedge clk); check("fma_busy3_t2", frf_busy_o[3], 1'b1);
    cyc(); fma_v_i = 1'b1; fma_data_i = 66'h1_2345_6789_ABCD_EF01; fma_fflags_i = 5'b00001;
    cyc(); @(negedge clk); check("fma_acc_t4", fflags_acc_o, 5'b00001);
    check("fma_busy3_t4", frf_busy_o[3], 1'b0);
    idle(2);

    // fma rd=4 at t0, imul rd=9 at t1 -> both complete at t3
    cyc(); issue(1'b1, 5'd4); fq.push_back('{5'd4, 66'h2_0000_0000_0000_0044, 5'b00010});
    cyc(); issue(1'b0, 5'd9); iq.push_back('{5'd9, 66'h0_DEAD_BEEF_0000_0009, 5'h0});
    cyc();
    cyc(); fma_v_i = 1'b1; fma_data_i = 66'h2_0000_0000_0000_0044; fma_fflags_i = 5'b00010;
    imul_v_i = 1'b1; imul_data_i = 66'h0_DEAD_BEEF_0000_0009;
    @(negedge clk); check("dual_both_v", {iwb_v_o, fwb_v_o}, 2'b11);
    cyc(); @(negedge clk); check("dual_acc", fflags_acc_o, 5'b00011);
    check("dual_busy_clear", {irf_busy_o, frf_busy_o}, 64'h0);
    idle(2);

    // flush at t1 poisons the fma in S1
    cyc(); issue(1'b1, 5'd5);
    cyc(); flush_i = 1'b1; @(negedge clk); check("flush1_busy5_t1", frf_busy_o[5], 1'b1);
    cyc(); @(negedge clk); check("flush1_busy5_t2", frf_busy_o[5], 1'b0);
    cyc(); fma_v_i = 1'b1; fma_data_i = 66'h5; fma_fflags_i = 5'b00100;
    @(negedge clk); check("flush1_fwb_v", fwb_v_o, 1'b0);
    cyc(); @(negedge clk); check("flush1_acc", fflags_acc_o, 5'b00011);
    check("flush1_err", err_o, 1'b0);
    idle(2);

    // flush at t2 leaves the fma intact; an imul issued with that flush is killed
    cyc(); issue(1'b1, 5'd6); fq.push_back('{5'd6, 66'h3_FFFF_0000_FFFF_0006, 5'b01000});
    cyc();
    cyc(); flush_i = 1'b1; issue(1'b0, 5'd10);
    @(negedge clk); check("flush2_busy6_t2", frf_busy_o[6], 1'b1);
    cyc(); fma_v_i = 1'b1; fma_data_i = 66'h3_FFFF_0000_FFFF_0006; fma_fflags_i = 5'b01000;
    @(negedge clk); check("flush2_busy10", irf_busy_o[10], 1'b0);
    cyc(); imul_v_i = 1'b1; imul_data_i = 66'hA;
    @(negedge clk); check("flush2_iwb_v", iwb_v_o, 1'b0);
    check("flush2_acc", fflags_acc_o, 5'b01011);
    idle(2);

    // clear wins over a same-cycle accumulate
    cyc(); issue(1'b1, 5'd8); fq.push_back('{5'd8, 66'h8, 5'b10000});
    cyc();
    cyc();
    cyc(); fma_v_i = 1'b1; fma_data_i = 66'h8; fma_fflags_i = 5'b10000; fflags_clr_i = 1'b1;
    cyc(); @(negedge clk); check("clr_acc", fflags_acc_o, 5'h0);
    check("pre_spurious_err", err_o, 1'b0);
    idle(2);

    // spurious fma_v_i sets a sticky error
    cyc(); fma_v_i = 1'b1; fma_data_i = 66'h1;
    cyc(); @(negedge clk); check("spurious_err", err_o, 1'b1);
    idle(3); @(negedge clk); check("spurious_err_sticky", err_o, 1'b1);

    // reset clears error; a late pipe valid right after reset is forgiven
    cyc(); reset_i = 1'b1;
    cyc();
    cyc(); reset_i = 1'b0; fma_v_i = 1'b1; imul_v_i = 1'b1;
    @(negedge clk); check("rst2_err", err_o, 1'b0);
    check("rst2_acc", fflags_acc_o, 5'h0);
    check("rst2_wb_v", {iwb_v_o, fwb_v_o}, 2'b00);
    cyc(); @(negedge clk); check("rst2_late_valid_err", err_o, 1'b0);
    idle(2);

    check("iq_drained", iq.size(), 0);
    check("fq_drained", fq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_be_fma_result_tracker.md
Name: bp_be_fma_result_tracker

Overview:
- Shadow pipeline that sits directly downstream of the FMA/IMUL pipe in the BE calculator.
- The FMA pipe returns data with a valid bit but carries no destination metadata. This block records rd address and destination file at issue and pairs them with returning imul/fma results.
- It suppresses writebacks killed by flush and drives per-register pending masks for the scoreboard.
- It accumulates sticky FP exception flags.

Parameters:
- dpath_width_p, 66, writeback data width (recoded FP/int datapath width).
- reg_addr_width_p, 5, architectural register index width.
- imul_latency_p, 3, cycles from issue to imul_v_i, counting the issue cycle as 1.
- fma_latency_p, 4, cycles from issue to fma_v_i, counting the issue cycle as 1.
- flush_depth_p, 1, number of registered tracker stages (after issue) killed by flush_i.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- issue_v_i  in  1  op dispatched to FMA pipe this cycle.
- issue_fma_i  in  1  1 = FP op (fma latency, FRF dest); 0 = imul (imul latency, IRF dest).
- issue_rd_i  in  reg_addr_width_p  destination register.
- flush_i  in  1  pipeline flush.
- imul_data_i  in  dpath_width_p  imul result from pipe.
- imul_v_i  in  1  imul result valid.
- fma_data_i  in  dpath_width_p  FP result from pipe.
- fma_fflags_i  in  5  FP exception flags, as rv64_fflags_s.
- fma_v_i  in  1  FP result valid.
- fflags_clr_i  in  1  clear sticky flag accumulator.
- iwb_v_o  out  1  integer writeback valid.
- iwb_rd_o  out  reg_addr_width_p  integer writeback address.
- iwb_data_o  out  dpath_width_p  integer writeback data.
- fwb_v_o  out  1  FP writeback valid.
- fwb_rd_o  out  reg_addr_width_p  FP writeback address.
- fwb_data_o  out  dpath_width_p  FP writeback data.
- fwb_fflags_o  out  5  flags of current FP writeback.
- fflags_acc_o  out  5  sticky OR of committed FP flags.
- irf_busy_o  out  32  pending IRF destinations.
- frf_busy_o  out  32  pending FRF destinations.
- err_o  out  1  sticky protocol error.

Behaviour:
- Clock and reset: one clock clk_i; reset_i synchronous active-high.
- Storage: a shift chain of fma_latency_p-1 entry registers S1..S(L-1). Each entry holds {v, poison, fp, rd}.
- Issue: at issue cycle t, the entry {issue_v_i, flush_i, issue_fma_i, issue_rd_i} loads into S1 at edge t+1; each stage shifts every cycle.
- Completion stages:
  - imul entries complete in stage S(imul_latency_p-1), i.e. S2 by default, the same cycle imul_v_i is high.
  - fp entries complete in S(fma_latency_p-1), i.e. S3 by default.
- Flush: when flush_i is high, the issuing op and entries in S1..S(flush_depth_p) get poison=1 on the next shift. Deeper stages are committed and unaffected. Flush does not clear v; the pipe still returns data.
- Integer writeback (combinational from stage regs and pipe inputs):
  - iwb_v_o = imul_v_i & completing imul entry v & !poison & !fp.
  - iwb_rd_o = that entry's rd; iwb_data_o = imul_data_i.
- FP writeback:
  - fwb_v_o = fma_v_i & completing fp entry v & !poison & fp.
  - fwb_rd_o, fwb_data_o and fwb_fflags_o are formed likewise.
- Same-cycle completion: imul and fp completions in the same cycle target different files; both ports assert together.
- Flags: fflags_acc_o |= fwb_fflags_o when fwb_v_o. fflags_clr_i has priority over a same-cycle accumulate (result = 0). Poisoned ops never set flags.
- Busy masks:
  - irf_busy_o[r] = 1 if any S1..S(imul stage) entry has v & !poison & !fp & rd==r.
  - frf_busy_o is the same for fp entries in S1..S(fp stage).
  - Bits clear the cycle after the writeback. Issue-cycle ops are excluded; the issuer handles same-cycle hazards.
  - Register 0 is never marked busy in irf_busy_o.
- err_o is sticky and set on any of:
  - imul_v_i without a valid imul entry at the imul stage, or the reverse;
  - fma_v_i without a valid fp entry at the fp stage, or the reverse.
- Reset: clears all entries, fflags_acc_o and err_o. All outputs read 0 in the cycle after reset. Ops in flight at reset are dropped silently; their late pipe valids are ignored for err_o for fma_latency_p-1 cycles after reset deasserts.

Decomposition:
- bp_be_pkg gets:
  - typedef bp_be_fma_track_entry_s {v, poison, fp, rd};
  - localparams for the imul and fp completion stage indices.
- rv64_fflags_s is reused from bp_common_pkg.
- One sub-module, bp_be_fma_track_stage: a single reset-able entry register with poison-on-flush input, instantiated L-1 times via generate.

Test Plan:
- imul issue at t0, rd=7 -> irf_busy_o[7]=1 at t1..t2; at t2 imul_v_i with data 0x2A gives iwb_v_o=1, iwb_rd_o=7, iwb_data_o=0x2A; irf_busy_o[7]=0 at t3.
- fmadd issue at t0, rd=3, fflags 5'b00001 at t3 -> fwb_v_o=1, fwb_rd_o=3 at t3; fflags_acc_o=5'b00001 at t4.
- fma issue at t0 (rd=4) and imul issue at t1 (rd=9) -> iwb_v_o and fwb_v_o both high at t3 with correct rd.
- fma issue at t0, flush_i at t1 -> S1 poisoned; fma_v_i at t3 gives fwb_v_o=0, flags unchanged, frf_busy_o[rd]=0 from t2; flush at t2 instead leaves the writeback intact.
- Spurious fma_v_i with no issue -> err_o=1 and stays high until reset.
- fflags_clr_i coincident with fwb_v_o carrying flags 5'b10000 -> fflags_acc_o=0 next cycle.
